// File: rtl/stepper_pkg.sv
// Shared types and helpers for the N-axis stepper controller.
//   axis_state_e : per-axis state encoding
//   axw_f        : width of an axis index for a given axis count
package stepper_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOME,
        ST_IDLE,
        ST_SETUP,
        ST_MOVE,
        ST_FAULT
    } axis_state_e;

    // A single-axis build still needs a 1-bit index port.
    function automatic int axw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stepper_axis.sv
// One motor channel: homing, absolute moves, limit fault handling.
// Ports:
//   sysclk_i, rst_ni            clock, async active-low reset
//   tick_i                      shared step-rate strobe
//   stop_i                      synchronised limit switch (1 = at home)
//   accept_i                    command accepted for this axis this cycle
//   cmd_home_i, cmd_pos_i       command payload
//   pu_o, dr_o, mf_o            pulse, direction (1 = away from home), motor free
//   busy_o, fault_o, idle_o     state flags
//   done_o                      one-cycle pulse on entering IDLE
//   pos_o                       current position
//
// state    | meaning
// ---------+------------------------------------------------------------
// RESET    | held in reset; windings free, leaves on first cycle after release
// HOME     | stepping toward home (DR=0) until Stop or step budget spent
// IDLE     | parked at pos, ready for a command
// SETUP    | DR settled, waiting one tick before the first pulse
// MOVE     | stepping toward tgt, one pulse every two ticks
// FAULT    | homing timeout or limit hit; windings free, needs cmd_home
module stepper_axis
    import stepper_pkg::*;
#(
    parameter int POS_W    = 10,
    parameter int POS_MAX  = 999,
    parameter int HOME_MAX = 1023
) (
    input  logic             sysclk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             stop_i,
    input  logic             accept_i,
    input  logic             cmd_home_i,
    input  logic [POS_W-1:0] cmd_pos_i,
    output logic             pu_o,
    output logic             dr_o,
    output logic             mf_o,
    output logic             busy_o,
    output logic             fault_o,
    output logic             idle_o,
    output logic             done_o,
    output logic [POS_W-1:0] pos_o
);

    localparam int HCW = $clog2(HOME_MAX + 1);
    localparam logic [POS_W-1:0] POS_MAX_C = POS_W'(POS_MAX);

    axis_state_e      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [HCW-1:0]   hcnt_q, hcnt_d;
    logic             pu_q, pu_d;
    logic             dr_q, dr_d;
    logic             done_q, done_d;
    logic             mf_q;
    logic [POS_W-1:0] tgt_clamped;

    assign tgt_clamped = (cmd_pos_i > POS_MAX_C) ? POS_MAX_C : cmd_pos_i;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        hcnt_d  = hcnt_q;
        pu_d    = pu_q;
        dr_d    = dr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_HOME;
                hcnt_d  = '0;
                pu_d    = 1'b0;
                dr_d    = 1'b0;
            end
            ST_HOME: begin
                dr_d = 1'b0;
                if (stop_i) begin
                    pu_d    = 1'b0;
                    pos_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (hcnt_q == HCW'(HOME_MAX)) begin
                    pu_d    = 1'b0;
                    state_d = ST_FAULT;
                end else if (tick_i) begin
                    pu_d = ~pu_q;
                    if (!pu_q) hcnt_d = hcnt_q + HCW'(1);
                end
            end
            ST_IDLE: begin
                if (accept_i) begin
                    if (cmd_home_i) begin
                        state_d = ST_HOME;
                        hcnt_d  = '0;
                        pu_d    = 1'b0;
                        dr_d    = 1'b0;
                    end else begin
                        tgt_d   = tgt_clamped;
                        dr_d    = (tgt_clamped > pos_q);
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (tick_i) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                // Only a move toward home can run into the limit switch.
                if (!dr_q && stop_i) begin
                    pu_d    = 1'b0;
                    pos_d   = '0;
                    state_d = ST_FAULT;
                end else if (tick_i) begin
                    if (pu_q) begin
                        pu_d = 1'b0;
                    end else if (pos_q == tgt_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pu_d  = 1'b1;
                        pos_d = dr_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                pu_d = 1'b0;
                if (accept_i && cmd_home_i) begin
                    state_d = ST_HOME;
                    hcnt_d  = '0;
                    dr_d    = 1'b0;
                end
            end
            default: state_d = ST_HOME;
        endcase
    end

    always_ff @(posedge sysclk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RESET;
            pos_q   <= '0;
            tgt_q   <= '0;
            hcnt_q  <= '0;
            pu_q    <= 1'b0;
            dr_q    <= 1'b0;
            done_q  <= 1'b0;
            mf_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            hcnt_q  <= hcnt_d;
            pu_q    <= pu_d;
            dr_q    <= dr_d;
            done_q  <= done_d;
            mf_q    <= (state_d == ST_FAULT);
        end
    end

    assign pu_o    = pu_q;
    assign dr_o    = dr_q;
    assign mf_o    = mf_q;
    assign done_o  = done_q;
    assign pos_o   = pos_q;
    assign busy_o  = (state_q == ST_HOME) || (state_q == ST_SETUP) || (state_q == ST_MOVE);
    assign fault_o = (state_q == ST_FAULT);
    assign idle_o  = (state_q == ST_IDLE);

endmodule

// File: rtl/stepper_axis_array.sv
// N-axis stepper controller top: step prescaler, limit-switch synchronisers,
// command decode / ready mux, position readback, and one stepper_axis per motor.
// Ports:
//   sysclk, rst_n                       clock, async active-low reset
//   Stop[N_AXES]                        async limit switches (1 = at home)
//   cmd_valid/cmd_ready                 command handshake
//   cmd_axis, cmd_pos, cmd_home         command payload
//   rd_axis -> rd_pos                   registered position readback
//   PU, DR, MF                          per-axis motor driver outputs
//   busy, fault, done                   per-axis status
module stepper_axis_array
    import stepper_pkg::*;
#(
    parameter int N_AXES   = 6,
    parameter int POS_W    = 10,
    parameter int POS_MAX  = 999,
    parameter int STEP_DIV = 50,
    parameter int HOME_MAX = 1023,
    localparam int AXW     = axw_f(N_AXES)
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [N_AXES-1:0] Stop,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AXW-1:0]    cmd_axis,
    input  logic [POS_W-1:0]  cmd_pos,
    input  logic              cmd_home,
    input  logic [AXW-1:0]    rd_axis,
    output logic [POS_W-1:0]  rd_pos,
    output logic [N_AXES-1:0] PU,
    output logic [N_AXES-1:0] DR,
    output logic [N_AXES-1:0] MF,
    output logic [N_AXES-1:0] busy,
    output logic [N_AXES-1:0] fault,
    output logic [N_AXES-1:0] done
);

    localparam int PSW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [PSW-1:0]    psc_q, psc_d;
    logic              tick;
    logic [N_AXES-1:0] stop_s1_q, stop_s2_q;
    logic [N_AXES-1:0] idle, axis_hit, accept;
    logic              sel_idle, sel_fault;
    logic [POS_W-1:0]  pos_w [N_AXES];
    logic [POS_W-1:0]  rd_pos_q, rd_pos_d;

    assign tick  = (psc_q == PSW'(STEP_DIV - 1));
    assign psc_d = tick ? '0 : psc_q + PSW'(1);

    // Out-of-range axis numbers are always ready so a stray command is
    // swallowed instead of stalling the front end.
    always_comb begin
        axis_hit  = '0;
        sel_idle  = 1'b0;
        sel_fault = 1'b0;
        for (int i = 0; i < N_AXES; i++) begin
            if (cmd_axis == AXW'(i)) begin
                axis_hit[i] = 1'b1;
                sel_idle    = idle[i];
                sel_fault   = fault[i];
            end
        end
        cmd_ready = !(|axis_hit) || sel_idle || (sel_fault && cmd_home);
    end

    assign accept = axis_hit & {N_AXES{cmd_valid & cmd_ready}};

    always_comb begin
        rd_pos_d = '0;
        for (int i = 0; i < N_AXES; i++) begin
            if (rd_axis == AXW'(i)) rd_pos_d = pos_w[i];
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q     <= '0;
            stop_s1_q <= '0;
            stop_s2_q <= '0;
            rd_pos_q  <= '0;
        end else begin
            psc_q     <= psc_d;
            stop_s1_q <= Stop;
            stop_s2_q <= stop_s1_q;
            rd_pos_q  <= rd_pos_d;
        end
    end

    assign rd_pos = rd_pos_q;

    for (genvar g = 0; g < N_AXES; g++) begin : g_axis
        stepper_axis #(
            .POS_W    (POS_W),
            .POS_MAX  (POS_MAX),
            .HOME_MAX (HOME_MAX)
        ) u_axis (
            .sysclk_i   (sysclk),
            .rst_ni     (rst_n),
            .tick_i     (tick),
            .stop_i     (stop_s2_q[g]),
            .accept_i   (accept[g]),
            .cmd_home_i (cmd_home),
            .cmd_pos_i  (cmd_pos),
            .pu_o       (PU[g]),
            .dr_o       (DR[g]),
            .mf_o       (MF[g]),
            .busy_o     (busy[g]),
            .fault_o    (fault[g]),
            .idle_o     (idle[g]),
            .done_o     (done[g]),
            .pos_o      (pos_w[g])
        );
    end

endmodule

// File: tb/tb_stepper_axis_array.sv
module tb_stepper_axis_array;

    localparam int N        = 6;
    localparam int STEP_DIV = 4;
    localparam int HOME_MAX = 20;

    logic        sysclk;
    logic        rst_n;
    logic [5:0]  Stop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_axis;
    logic [9:0]  cmd_pos;
    logic        cmd_home;
    logic [2:0]  rd_axis;
    logic [9:0]  rd_pos;
    logic [5:0]  PU, DR, MF, busy, fault, done;

    stepper_axis_array #(
        .N_AXES   (N),
        .POS_W    (10),
        .POS_MAX  (999),
        .STEP_DIV (STEP_DIV),
        .HOME_MAX (HOME_MAX)
    ) dut (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .Stop      (Stop),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_axis  (cmd_axis),
        .cmd_pos   (cmd_pos),
        .cmd_home  (cmd_home),
        .rd_axis   (rd_axis),
        .rd_pos    (rd_pos),
        .PU        (PU),
        .DR        (DR),
        .MF        (MF),
        .busy      (busy),
        .fault     (fault),
        .done      (done)
    );

    typedef struct {
        bit is_fault;
        int rises;
    } ev_t;

    ev_t exp_q [N][$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(input int ax, input bit is_fault, input int rises);
        ev_t e;
        e.is_fault = is_fault;
        e.rises    = rises;
        exp_q[ax].push_back(e);
    endfunction

    // Monitor: counts PU rises per axis, checks the step period, and pops the
    // expected completion/fault record whenever an axis reports one.
    initial begin
        int         rises [N];
        int         last_rise [N];
        bit         have_rise [N];
        logic [5:0] pu_prev;
        logic [5:0] fault_prev;
        ev_t        e;
        pu_prev    = '0;
        fault_prev = '0;
        for (int i = 0; i < N; i++) begin
            rises[i] = 0; last_rise[i] = 0; have_rise[i] = 0;
        end
        forever begin
            @(negedge sysclk);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    rises[i] = 0; have_rise[i] = 0;
                end
                pu_prev    = '0;
                fault_prev = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (PU[i] && !pu_prev[i]) begin
                        if (have_rise[i])
                            chk($sformatf("pu_period_ax%0d", i), cyc - last_rise[i], 2 * STEP_DIV);
                        have_rise[i] = 1;
                        last_rise[i] = cyc;
                        rises[i]++;
                    end
                    if (done[i] || (fault[i] && !fault_prev[i])) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_event_ax%0d: got done=%0d fault=%0d, expected no event",
                                     i, done[i], fault[i]);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk($sformatf("event_is_fault_ax%0d", i), done[i] ? 0 : 1, int'(e.is_fault));
                            chk($sformatf("event_rises_ax%0d", i), rises[i], e.rises);
                        end
                        rises[i]     = 0;
                        have_rise[i] = 0;
                    end
                end
                pu_prev    = PU;
                fault_prev = fault;
            end
        end
    end

    task automatic send(input int ax, input int pos, input bit home, input int budget);
        int n;
        cmd_axis  = 3'(ax);
        cmd_pos   = 10'(pos);
        cmd_home  = home;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        chk($sformatf("send_ready_ax%0d", ax), int'(cmd_ready), 1);
        @(negedge sysclk);
        cmd_valid = 1'b0;
        cmd_home  = 1'b0;
    endtask

    task automatic wait_idle(input int ax, input int budget);
        int n;
        n = 0;
        while (busy[ax] && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        chk($sformatf("idle_ax%0d", ax), int'(busy[ax]), 0);
    endtask

    task automatic check_rd(input int ax, input int exp);
        rd_axis = 3'(ax);
        repeat (2) @(negedge sysclk);
        chk($sformatf("rd_pos_ax%0d", ax), int'(rd_pos), exp);
    endtask

    initial begin
        int         th [N];
        int         cnt [N];
        logic [5:0] pp;
        int         n;
        logic       p1;

        th = '{5, 0, 2, -1, 4, 8};
        rst_n     = 1'b0;
        Stop      = 6'b000010;
        cmd_valid = 1'b0;
        cmd_axis  = '0;
        cmd_pos   = '0;
        cmd_home  = 1'b0;
        rd_axis   = '0;

        expect_ev(0, 0, 5);
        expect_ev(1, 0, 0);
        expect_ev(2, 0, 2);
        expect_ev(3, 1, HOME_MAX);
        expect_ev(4, 0, 4);
        expect_ev(5, 0, 8);

        repeat (3) @(negedge sysclk);
        chk("rst_PU", PU, 0);
        chk("rst_DR", DR, 0);
        chk("rst_MF", MF, 6'h3f);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_pos", rd_pos, 0);

        rst_n = 1'b1;
        @(negedge sysclk);
        chk("home_entry_busy", busy, 6'h3f);
        chk("home_entry_MF", MF, 0);

        for (int i = 0; i < N; i++) cnt[i] = 0;
        pp = '0;
        n  = 0;
        while (busy != 0 && n < 400) begin
            @(negedge sysclk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (PU[i] && !pp[i]) cnt[i]++;
                if (th[i] > 0 && cnt[i] == th[i]) Stop[i] = 1'b1;
            end
            pp = PU;
        end
        chk("homing_all_settled", busy, 0);
        chk("homing_MF", MF, 6'b001000);
        chk("homing_fault", fault, 6'b001000);
        cmd_axis = 3'd3;
        cmd_home = 1'b0;
        #1;
        chk("ready_move_to_faulted", cmd_ready, 0);
        cmd_home = 1'b1;
        #1;
        chk("ready_home_to_faulted", cmd_ready, 1);
        cmd_home = 1'b0;
        Stop = '0;
        repeat (4) @(negedge sysclk);
        check_rd(0, 0);

        // Axis 5: forward 11 steps, then back 3.
        expect_ev(5, 0, 11);
        send(5, 11, 0, 20);
        chk("move_fwd_DR5", DR[5], 1);
        wait_idle(5, 400);
        check_rd(5, 11);
        expect_ev(5, 0, 3);
        send(5, 8, 0, 20);
        chk("move_rev_DR5", DR[5], 0);
        wait_idle(5, 400);
        check_rd(5, 8);

        // Axis 2: clamped long move, stray command, then blocked null move.
        expect_ev(2, 0, 999);
        send(2, 1000, 0, 20);
        chk("clamp_DR2", DR[2], 1);
        cmd_axis = 3'd7;
        #1;
        chk("ready_out_of_range", cmd_ready, 1);
        send(7, 3, 0, 10);
        @(negedge sysclk);
        chk("stray_busy", busy, 6'b000100);
        chk("stray_fault", fault, 6'b001000);
        cmd_axis  = 3'd2;
        cmd_pos   = 10'd999;
        cmd_valid = 1'b1;
        #1;
        chk("ready_busy_axis", cmd_ready, 0);
        expect_ev(2, 0, 0);
        send(2, 999, 0, 9000);
        wait_idle(2, 100);
        check_rd(2, 999);

        // Axis 1: out to 10, then limit switch hit on the way back.
        expect_ev(1, 0, 10);
        send(1, 10, 0, 20);
        wait_idle(1, 400);
        expect_ev(1, 1, 4);
        send(1, 0, 0, 20);
        chk("limit_DR1", DR[1], 0);
        n  = 0;
        cnt[1] = 0;
        p1 = PU[1];
        while (cnt[1] < 4 && n < 200) begin
            @(negedge sysclk);
            n++;
            if (PU[1] && !p1) cnt[1]++;
            p1 = PU[1];
        end
        chk("limit_rises_seen", cnt[1], 4);
        Stop[1] = 1'b1;
        repeat (3) @(negedge sysclk);
        chk("limit_PU1", PU[1], 0);
        chk("limit_fault1", fault[1], 1);
        chk("limit_MF1", MF[1], 1);
        check_rd(1, 0);
        expect_ev(1, 0, 0);
        send(1, 0, 1, 20);
        wait_idle(1, 100);
        chk("rehome_fault1", fault[1], 0);
        Stop[1] = 1'b0;
        repeat (4) @(negedge sysclk);

        // Reset in the middle of a move.
        send(5, 40, 0, 20);
        n = 0;
        while (!PU[5] && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        chk("pre_reset_PU5", PU[5], 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_PU", PU, 0);
        chk("midrst_DR", DR, 0);
        chk("midrst_MF", MF, 6'h3f);
        chk("midrst_busy", busy, 0);
        chk("midrst_fault", fault, 0);
        Stop = 6'h3f;
        for (int i = 0; i < N; i++) expect_ev(i, 0, 0);
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (8) @(negedge sysclk);
        chk("rehome_busy", busy, 0);
        chk("rehome_MF", MF, 0);
        chk("rehome_fault", fault, 0);

        @(negedge sysclk);
        for (int i = 0; i < N; i++)
            chk($sformatf("pending_events_ax%0d", i), exp_q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
